// File: rtl/tri_dispatch.sv
// Triangle record dispatcher: fetches 15-word records into a shadow buffer and
// presents them to the vertex stage through a valid/busy slot handshake.
module tri_dispatch #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  tri_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              vs_busy,
    output logic [14:0][31:0] v_out,
    output logic [23:0]       color_out1,
    output logic [23:0]       color_out2,
    output logic [23:0]       color_out3,
    output logic              tri_valid,
    output logic              tri_last,
    output logic              busy,
    output logic              done
);
    localparam logic [3:0] LAST_WORD  = 4'd14;
    localparam logic [3:0] READS_DONE = 4'd15;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic [CNT_W-1:0]   remain_reg;
    logic [3:0]         rd_idx_reg;
    logic [3:0]         cap_idx_reg;
    logic [MEM_LAT-1:0] rd_pipe_reg;
    logic [14:0][31:0]  shadow_reg;

    logic capture, last_capture, slot_free, accept, final_tri;
    logic start_batch, start_empty, copy_en;

    assign capture      = rd_pipe_reg[MEM_LAT-1];
    assign last_capture = capture && (cap_idx_reg == LAST_WORD);
    assign slot_free    = !tri_valid && !vs_busy;
    assign accept       = tri_valid && vs_busy;
    assign final_tri    = (remain_reg == CNT_W'(1));
    assign start_batch  = (state_reg == IDLE) && start && (tri_count != '0);
    assign start_empty  = (state_reg == IDLE) && start && (tri_count == '0);

    assign mem_addr   = addr_reg;
    assign color_out1 = v_out[3][23:0];
    assign color_out2 = v_out[7][23:0];
    assign color_out3 = v_out[11][23:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start_batch) state_next = FETCH;
            FETCH:     if (last_capture) state_next = WAIT_SLOT;
            WAIT_SLOT: if (slot_free) state_next = final_tri ? DRAIN : FETCH;
            DRAIN:     if (accept) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd  = 1'b0;
        copy_en = 1'b0;
        case (state_reg)
            FETCH:     mem_rd  = (rd_idx_reg != READS_DONE);
            WAIT_SLOT: copy_en = slot_free;
            default:   ;
        endcase
    end

    // Delay line marking which cycles return read data into the shadow buffer.
    generate
        if (MEM_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) rd_pipe_reg <= '0;
                else        rd_pipe_reg <= mem_rd;
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) rd_pipe_reg <= '0;
                else        rd_pipe_reg <= {rd_pipe_reg[MEM_LAT-2:0], mem_rd};
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_reg    <= '0;
            remain_reg  <= '0;
            rd_idx_reg  <= '0;
            cap_idx_reg <= '0;
            shadow_reg  <= '0;
            v_out       <= '0;
            tri_valid   <= 1'b0;
            tri_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= start_empty;
            if (start_batch) begin
                addr_reg    <= base_addr;
                remain_reg  <= tri_count;
                busy        <= 1'b1;
                rd_idx_reg  <= '0;
                cap_idx_reg <= '0;
            end
            if (mem_rd) begin
                addr_reg   <= addr_reg + ADDR_W'(1);
                rd_idx_reg <= rd_idx_reg + 4'd1;
            end
            if (capture) begin
                shadow_reg[cap_idx_reg] <= mem_rdata;
                cap_idx_reg             <= cap_idx_reg + 4'd1;
            end
            // A copy needs an empty slot, so it can never coincide with an accept.
            if (copy_en) begin
                v_out       <= shadow_reg;
                tri_valid   <= 1'b1;
                tri_last    <= final_tri;
                remain_reg  <= remain_reg - CNT_W'(1);
                rd_idx_reg  <= '0;
                cap_idx_reg <= '0;
            end else if (accept) begin
                tri_valid <= 1'b0;
            end
            if ((state_reg == DRAIN) && accept) begin
                done     <= 1'b1;
                busy     <= 1'b0;
                tri_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tri_dispatch.sv
// Directed bench for tri_dispatch: default instance (16-bit, latency 1) and a
// narrow-address, latency-3 instance for wrap and latency checks.
module tb_tri_dispatch;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    logic              start, vs_busy, mem_rd, tri_valid, tri_last, busy, done;
    logic [15:0]       base_addr, tri_count, mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic [14:0][31:0] v_out;
    logic [23:0]       color_out1, color_out2, color_out3;

    logic              w_start, w_vs_busy, w_mem_rd, w_tri_valid, w_tri_last, w_busy, w_done;
    logic [7:0]        w_base_addr, w_mem_addr;
    logic [15:0]       w_tri_count;
    logic [31:0]       w_mem_rdata = '0;
    logic [31:0]       w_pipe1 = '0;
    logic [31:0]       w_pipe2 = '0;
    logic [14:0][31:0] w_v_out;
    logic [23:0]       w_color_out1, w_color_out2, w_color_out3;

    tri_dispatch dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .tri_count(tri_count), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .vs_busy(vs_busy), .v_out(v_out),
        .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
        .tri_valid(tri_valid), .tri_last(tri_last), .busy(busy), .done(done)
    );

    tri_dispatch #(.ADDR_W(8), .MEM_LAT(3), .CNT_W(16)) dut_w (
        .clock(clock), .reset(reset), .start(w_start), .base_addr(w_base_addr),
        .tri_count(w_tri_count), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
        .mem_rdata(w_mem_rdata), .vs_busy(w_vs_busy), .v_out(w_v_out),
        .color_out1(w_color_out1), .color_out2(w_color_out2), .color_out3(w_color_out3),
        .tri_valid(w_tri_valid), .tri_last(w_tri_last), .busy(w_busy), .done(w_done)
    );

    // Triangle buffers: word content encodes its own address.
    always @(posedge clock) if (mem_rd) mem_rdata <= 32'h1000_0000 + 32'(mem_addr);
    always @(posedge clock) begin
        w_pipe1     <= 32'h2000_0000 + 32'(w_mem_addr);
        w_pipe2     <= w_pipe1;
        w_mem_rdata <= w_pipe2;
    end

    task automatic start_a(input logic [15:0] b, input logic [15:0] c);
        start = 1'b1; base_addr = b; tri_count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic accept_a();
        vs_busy = 1'b1;
        @(negedge clock);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL accept_done: got %b want 1", done); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL accept_busy: got %b want 0", busy); end
        vs_busy = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        vecs++; if ({mem_rd, tri_valid, tri_last, busy, done} !== 5'b0) begin errs++; $display("FAIL reset_ctl: got %b want 00000", {mem_rd, tri_valid, tri_last, busy, done}); end
        vecs++; if (v_out !== '0 || mem_addr !== 16'h0) begin errs++; $display("FAIL reset_data: got v0=%h addr=%h want 0", v_out[0], mem_addr); end
        vecs++; if ({color_out1, color_out2, color_out3} !== 72'h0) begin errs++; $display("FAIL reset_color: got %h want 0", {color_out1, color_out2, color_out3}); end
        reset = 1'b1;
        @(negedge clock);
        vecs++; if ({mem_rd, tri_valid, busy, done, w_mem_rd, w_tri_valid, w_busy} !== 7'b0) begin errs++; $display("FAIL post_reset_idle: got %b want 0", {mem_rd, tri_valid, busy, done, w_mem_rd, w_tri_valid, w_busy}); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int rd_n, first_v;
        rd_n = 0; first_v = -1;
        start_a(16'h0100, 16'd1);
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            if (mem_rd) begin
                vecs++; if (mem_addr !== 16'h0100 + 16'(rd_n) || k != rd_n) begin errs++; $display("FAIL single_rd: k=%0d got %h want %h at k=%0d", k, mem_addr, 16'h0100 + 16'(rd_n), rd_n); end
                rd_n++;
            end
            if (tri_valid) first_v = k; else @(negedge clock);
        end
        vecs++; if (rd_n != 15) begin errs++; $display("FAIL single_nreads: got %0d want 15", rd_n); end
        vecs++; if (first_v != 17) begin errs++; $display("FAIL single_latency: got E%0d want E17", first_v); end
        vecs++; if (v_out[0] !== 32'h1000_0100 || v_out[14] !== 32'h1000_010E) begin errs++; $display("FAIL single_data: got %h %h want 10000100 1000010e", v_out[0], v_out[14]); end
        vecs++; if (color_out1 !== 24'h000103) begin errs++; $display("FAIL single_color1: got %h want 000103", color_out1); end
        vecs++; if (tri_last !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL single_last_busy: got %b%b want 11", tri_last, busy); end
        @(negedge clock);
        vs_busy = 1'b1;
        vecs++; if (tri_valid !== 1'b1) begin errs++; $display("FAIL single_hold: got %b want 1", tri_valid); end
        @(negedge clock);
        vecs++; if ({tri_valid, done, busy, tri_last} !== 4'b0100) begin errs++; $display("FAIL single_accept: got %b want 0100", {tri_valid, done, busy, tri_last}); end
        vecs++; if (v_out[0] !== 32'h1000_0100) begin errs++; $display("FAIL single_vout_kept: got %h want 10000100", v_out[0]); end
        @(negedge clock);
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL single_done_width: got %b want 0", done); end
        repeat (2) @(negedge clock);
        vs_busy = 1'b0;
        @(negedge clock);
        $display("test_single done: reads=%0d valid_at=E%0d", rd_n, first_v);
    endtask

    task automatic test_back_to_back();
        int rd_n, pres, dones, unstable, vcnt;
        logic prev_tv;
        logic [14:0][31:0] prev_v;
        rd_n = 0; pres = 0; dones = 0; unstable = 0; vcnt = 0; prev_tv = 1'b0; prev_v = '0;
        start_a(16'h0100, 16'd3);
        for (int k = 0; k < 250; k++) begin
            if (mem_rd) begin
                vecs++; if (mem_addr !== 16'h0100 + 16'(rd_n)) begin errs++; $display("FAIL b2b_rd: got %h want %h", mem_addr, 16'h0100 + 16'(rd_n)); end
                rd_n++;
            end
            if (done) dones++;
            if (tri_valid && prev_tv && v_out !== prev_v) unstable++;
            if (tri_valid && !prev_tv) begin
                vecs++; if (v_out[0] !== 32'h1000_0100 + 32'(15 * pres)) begin errs++; $display("FAIL b2b_first_word: tri %0d got %h want %h", pres, v_out[0], 32'h1000_0100 + 32'(15 * pres)); end
                vecs++; if (tri_last !== ((pres == 2) ? 1'b1 : 1'b0)) begin errs++; $display("FAIL b2b_last: tri %0d got %b", pres, tri_last); end
                pres++;
            end
            prev_tv = tri_valid;
            prev_v  = v_out;
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) vs_busy = 1'b0;
            end else if (tri_valid) begin
                vs_busy = 1'b1;
                vcnt = 20;
            end
            @(negedge clock);
        end
        vecs++; if (rd_n != 45) begin errs++; $display("FAIL b2b_nreads: got %0d want 45", rd_n); end
        vecs++; if (pres != 3) begin errs++; $display("FAIL b2b_presentations: got %0d want 3", pres); end
        vecs++; if (dones != 1) begin errs++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
        vecs++; if (unstable != 0) begin errs++; $display("FAIL b2b_vout_stable: got %0d changes want 0", unstable); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        $display("test_back_to_back done: reads=%0d presentations=%0d dones=%0d", rd_n, pres, dones);
    endtask

    task automatic test_slow_consumer();
        int rd_n, first_v, tv_err;
        rd_n = 0; first_v = -1; tv_err = 0;
        start_a(16'h0200, 16'd2);
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            if (mem_rd) rd_n++;
            if (tri_valid) first_v = k; else @(negedge clock);
        end
        vecs++; if (first_v != 17) begin errs++; $display("FAIL slow_first_latency: got E%0d want E17", first_v); end
        vs_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (mem_rd) rd_n++;
            if (tri_valid) tv_err++;
        end
        vs_busy = 1'b0;
        vecs++; if (rd_n != 30) begin errs++; $display("FAIL slow_nreads: got %0d want 30", rd_n); end
        vecs++; if (tv_err != 0 || tri_valid !== 1'b0) begin errs++; $display("FAIL slow_no_early_valid: got %0d cycles want 0", tv_err); end
        @(negedge clock);
        if (mem_rd) rd_n++;
        vecs++; if (tri_valid !== 1'b1) begin errs++; $display("FAIL slow_valid_after_release: got %b want 1", tri_valid); end
        vecs++; if (v_out[0] !== 32'h1000_020F || v_out[14] !== 32'h1000_021D) begin errs++; $display("FAIL slow_data: got %h %h want 1000020f 1000021d", v_out[0], v_out[14]); end
        vecs++; if (color_out3 !== 24'h00021A || tri_last !== 1'b1) begin errs++; $display("FAIL slow_color3_last: got %h %b want 00021a 1", color_out3, tri_last); end
        accept_a();
        if (mem_rd) rd_n++;
        vecs++; if (rd_n != 30) begin errs++; $display("FAIL slow_no_extra_reads: got %0d want 30", rd_n); end
        $display("test_slow_consumer done: reads=%0d", rd_n);
    endtask

    task automatic test_zero_and_ignored_start();
        int rd_n, first_v;
        start_a(16'h0700, 16'd0);
        vecs++; if ({done, busy, mem_rd} !== 3'b100) begin errs++; $display("FAIL zero_done: got %b want 100", {done, busy, mem_rd}); end
        @(negedge clock);
        vecs++; if ({done, busy, mem_rd} !== 3'b000) begin errs++; $display("FAIL zero_after: got %b want 000", {done, busy, mem_rd}); end
        rd_n = 0; first_v = -1;
        start_a(16'h0300, 16'd1);
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            start = (k == 5);
            if (k == 5) begin base_addr = 16'h0500; tri_count = 16'd2; end
            if (mem_rd) begin
                vecs++; if (mem_addr !== 16'h0300 + 16'(rd_n)) begin errs++; $display("FAIL ignored_start_rd: got %h want %h", mem_addr, 16'h0300 + 16'(rd_n)); end
                rd_n++;
            end
            if (tri_valid) first_v = k; else @(negedge clock);
        end
        start = 1'b0;
        vecs++; if (rd_n != 15 || first_v != 17) begin errs++; $display("FAIL ignored_start_seq: got %0d reads valid E%0d want 15 E17", rd_n, first_v); end
        vecs++; if (tri_last !== 1'b1 || v_out[0] !== 32'h1000_0300) begin errs++; $display("FAIL ignored_start_data: got %b %h want 1 10000300", tri_last, v_out[0]); end
        accept_a();
        repeat (3) @(negedge clock);
        vecs++; if ({busy, mem_rd, tri_valid} !== 3'b000) begin errs++; $display("FAIL ignored_start_idle: got %b want 000", {busy, mem_rd, tri_valid}); end
        $display("test_zero_and_ignored_start done: reads=%0d", rd_n);
    endtask

    task automatic test_wrap_latency();
        int rd_n, first_v;
        rd_n = 0; first_v = -1;
        w_start = 1'b1; w_base_addr = 8'hF8; w_tri_count = 16'd1;
        @(negedge clock);
        w_start = 1'b0;
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            if (w_mem_rd) begin
                vecs++; if (w_mem_addr !== 8'(8'hF8 + rd_n) || (rd_n == 8 && w_mem_addr !== 8'h00)) begin errs++; $display("FAIL wrap_rd: read %0d got %h want %h", rd_n, w_mem_addr, 8'(8'hF8 + rd_n)); end
                rd_n++;
            end
            if (w_tri_valid) first_v = k; else @(negedge clock);
        end
        vecs++; if (rd_n != 15) begin errs++; $display("FAIL wrap_nreads: got %0d want 15", rd_n); end
        vecs++; if (first_v != 19) begin errs++; $display("FAIL wrap_latency: got E%0d want E19", first_v); end
        vecs++; if (w_v_out[0] !== 32'h2000_00F8 || w_v_out[8] !== 32'h2000_0000 || w_v_out[14] !== 32'h2000_0006) begin errs++; $display("FAIL wrap_data: got %h %h %h want 200000f8 20000000 20000006", w_v_out[0], w_v_out[8], w_v_out[14]); end
        vecs++; if (w_color_out1 !== 24'h0000FB || w_tri_last !== 1'b1) begin errs++; $display("FAIL wrap_color_last: got %h %b want 0000fb 1", w_color_out1, w_tri_last); end
        w_vs_busy = 1'b1;
        @(negedge clock);
        vecs++; if ({w_done, w_busy, w_tri_valid} !== 3'b100) begin errs++; $display("FAIL wrap_accept: got %b want 100", {w_done, w_busy, w_tri_valid}); end
        w_vs_busy = 1'b0;
        @(negedge clock);
        $display("test_wrap_latency done: reads=%0d valid_at=E%0d", rd_n, first_v);
    endtask

    task automatic test_reset_mid_batch();
        int first_v, dones;
        first_v = -1; dones = 0;
        start_a(16'h0100, 16'd3);
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            if (tri_valid) first_v = k; else @(negedge clock);
        end
        vs_busy = 1'b1;
        repeat (5) @(negedge clock);
        vecs++; if (mem_rd !== 1'b1) begin errs++; $display("FAIL rst_mid_fetching: got %b want 1", mem_rd); end
        #2 reset = 1'b0;
        #1;
        vecs++; if ({mem_rd, tri_valid, tri_last, busy, done} !== 5'b0 || mem_addr !== 16'h0) begin errs++; $display("FAIL rst_mid_ctl: got %b addr %h want 0", {mem_rd, tri_valid, tri_last, busy, done}, mem_addr); end
        vecs++; if (v_out !== '0 || color_out2 !== 24'h0) begin errs++; $display("FAIL rst_mid_data: got %h %h want 0", v_out[0], color_out2); end
        vs_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        vecs++; if (dones != 0 || busy !== 1'b0 || mem_rd !== 1'b0) begin errs++; $display("FAIL rst_mid_no_done: got %0d dones busy %b rd %b want 0", dones, busy, mem_rd); end
        start_a(16'h0400, 16'd1);
        vecs++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0400) begin errs++; $display("FAIL rst_restart_addr: got %b %h want 1 0400", mem_rd, mem_addr); end
        first_v = -1;
        for (int k = 0; k < 40 && first_v < 0; k++) begin
            if (tri_valid) first_v = k; else @(negedge clock);
        end
        vecs++; if (first_v != 17 || v_out[0] !== 32'h1000_0400) begin errs++; $display("FAIL rst_restart_data: got E%0d %h want E17 10000400", first_v, v_out[0]); end
        accept_a();
        $display("test_reset_mid_batch done");
    endtask

    initial begin
        start = 1'b0; vs_busy = 1'b0; base_addr = '0; tri_count = '0;
        w_start = 1'b0; w_vs_busy = 1'b0; w_base_addr = '0; w_tri_count = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_consumer();
        test_zero_and_ignored_start();
        test_wrap_latency();
        test_reset_mid_batch();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
